// File: rtl/vga_pkg.sv
// Framebuffer geometry, fill-engine state encoding and clip helper shared with the display stage.
package vga_pkg;

  localparam int unsigned FB_WIDTH      = 160;
  localparam int unsigned FB_HEIGHT     = 120;
  localparam int unsigned FB_COLOR_BITS = 9;
  localparam int unsigned FB_WORDS      = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_X_BITS     = $clog2(FB_WIDTH);
  localparam int unsigned FB_Y_BITS     = $clog2(FB_HEIGHT);

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_CLIP = 2'd1,
    FILL_DRAW = 2'd2,
    FILL_DONE = 2'd3
  } fill_state_e;

  // min(base+len, limit) with a 33-bit sum so huge edges never wrap back into range
  function automatic logic [31:0] clip_end(input logic [31:0] base,
                                           input logic [31:0] len,
                                           input logic [31:0] limit);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, len};
    return (sum > {1'b0, limit}) ? limit : sum[31:0];
  endfunction

endpackage

// File: rtl/rect_fill_engine.sv
// Rectangle-fill pixel generator: clips a command to the framebuffer and emits
// one registered pixel write per clock in raster order.
module rect_fill_engine
  import vga_pkg::*;
(
  input  logic        Fast_Clock,
  input  logic        Reset_N,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic [31:0] Cmd_X,
  input  logic [31:0] Cmd_Y,
  input  logic [31:0] Cmd_W,
  input  logic [31:0] Cmd_H,
  input  logic [31:0] Cmd_Color,
  output logic        Enable_Draw,
  output logic [31:0] Draw_X,
  output logic [31:0] Draw_Y,
  output logic [31:0] Draw_Color,
  output logic        Busy,
  output logic        Done
);

  fill_state_e              state_q, state_d;
  logic [31:0]              cmd_x_q, cmd_x_d;
  logic [31:0]              cmd_y_q, cmd_y_d;
  logic [31:0]              cmd_w_q, cmd_w_d;
  logic [31:0]              cmd_h_q, cmd_h_d;
  logic [FB_COLOR_BITS-1:0] color_q, color_d;
  logic [FB_X_BITS-1:0]     x_end_q, x_end_d;
  logic [FB_Y_BITS-1:0]     y_end_q, y_end_d;
  logic [FB_X_BITS-1:0]     cur_x_q, cur_x_d;
  logic [FB_Y_BITS-1:0]     cur_y_q, cur_y_d;

  logic                     cmd_ready_q, cmd_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     enable_q, enable_d;
  logic [FB_X_BITS-1:0]     draw_x_q, draw_x_d;
  logic [FB_Y_BITS-1:0]     draw_y_q, draw_y_d;
  logic [FB_COLOR_BITS-1:0] draw_color_q, draw_color_d;

  logic [31:0]              x_end_c, y_end_c;
  logic                     empty_c;
  logic [FB_X_BITS-1:0]     x_next_c;
  logic [FB_Y_BITS-1:0]     y_next_c;
  logic                     unused_bits;

  assign x_end_c  = clip_end(cmd_x_q, cmd_w_q, 32'(FB_WIDTH));
  assign y_end_c  = clip_end(cmd_y_q, cmd_h_q, 32'(FB_HEIGHT));
  assign empty_c  = (cmd_w_q == 32'd0) || (cmd_h_q == 32'd0) ||
                    (cmd_x_q >= 32'(FB_WIDTH)) || (cmd_y_q >= 32'(FB_HEIGHT));
  assign x_next_c = cur_x_q + FB_X_BITS'(1);
  assign y_next_c = cur_y_q + FB_Y_BITS'(1);

  // Clipped ends always fit the narrow counters; only the colour LSBs are meaningful.
  assign unused_bits = ^{x_end_c[31:FB_X_BITS], y_end_c[31:FB_Y_BITS],
                         Cmd_Color[31:FB_COLOR_BITS]};

  // Next-state and registered-output logic; outputs lag the state by one cycle.
  always_comb begin
    state_d      = state_q;
    cmd_x_d      = cmd_x_q;
    cmd_y_d      = cmd_y_q;
    cmd_w_d      = cmd_w_q;
    cmd_h_d      = cmd_h_q;
    color_d      = color_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    draw_x_d     = draw_x_q;
    draw_y_d     = draw_y_q;
    draw_color_d = draw_color_q;

    unique case (state_q)
      FILL_IDLE: begin
        if (Cmd_Valid && cmd_ready_q) begin
          cmd_x_d = Cmd_X;
          cmd_y_d = Cmd_Y;
          cmd_w_d = Cmd_W;
          cmd_h_d = Cmd_H;
          color_d = Cmd_Color[FB_COLOR_BITS-1:0];
          state_d = FILL_CLIP;
        end
      end
      FILL_CLIP: begin
        x_end_d = x_end_c[FB_X_BITS-1:0];
        y_end_d = y_end_c[FB_Y_BITS-1:0];
        if (empty_c) begin
          state_d = FILL_DONE;
        end else begin
          cur_x_d = cmd_x_q[FB_X_BITS-1:0];
          cur_y_d = cmd_y_q[FB_Y_BITS-1:0];
          state_d = FILL_DRAW;
        end
      end
      FILL_DRAW: begin
        if (x_next_c == x_end_q) begin
          cur_x_d = cmd_x_q[FB_X_BITS-1:0];
          if (y_next_c == y_end_q) begin
            state_d = FILL_DONE;
          end else begin
            cur_y_d = y_next_c;
          end
        end else begin
          cur_x_d = x_next_c;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase

    enable_d    = (state_q == FILL_DRAW);
    done_d      = (state_q == FILL_DONE);
    cmd_ready_d = (state_d == FILL_IDLE);
    busy_d      = (state_d != FILL_IDLE);
    if (state_q == FILL_DRAW) begin
      draw_x_d     = cur_x_q;
      draw_y_d     = cur_y_q;
      draw_color_d = color_q;
    end
  end

  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q      <= FILL_IDLE;
      cmd_x_q      <= '0;
      cmd_y_q      <= '0;
      cmd_w_q      <= '0;
      cmd_h_q      <= '0;
      color_q      <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      enable_q     <= 1'b0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      draw_color_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_x_q      <= cmd_x_d;
      cmd_y_q      <= cmd_y_d;
      cmd_w_q      <= cmd_w_d;
      cmd_h_q      <= cmd_h_d;
      color_q      <= color_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      enable_q     <= enable_d;
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      draw_color_q <= draw_color_d;
    end
  end

  assign Cmd_Ready   = cmd_ready_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Enable_Draw = enable_q;
  assign Draw_X      = 32'(draw_x_q);
  assign Draw_Y      = 32'(draw_y_q);
  assign Draw_Color  = 32'(draw_color_q);

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine.
module tb_rect_fill_engine;

  logic        Fast_Clock;
  logic        Reset_N;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [31:0] Cmd_X, Cmd_Y, Cmd_W, Cmd_H, Cmd_Color;
  logic        Enable_Draw;
  logic [31:0] Draw_X, Draw_Y, Draw_Color;
  logic        Busy;
  logic        Done;

  rect_fill_engine dut (
    .Fast_Clock (Fast_Clock),
    .Reset_N    (Reset_N),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_X      (Cmd_X),
    .Cmd_Y      (Cmd_Y),
    .Cmd_W      (Cmd_W),
    .Cmd_H      (Cmd_H),
    .Cmd_Color  (Cmd_Color),
    .Enable_Draw(Enable_Draw),
    .Draw_X     (Draw_X),
    .Draw_Y     (Draw_Y),
    .Draw_Color (Draw_Color),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial Fast_Clock = 1'b0;
  always #5 Fast_Clock = ~Fast_Clock;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int wr_x[$];
  int wr_y[$];
  int wr_c[$];
  int wr_cyc[$];
  int done_cyc[$];
  int oob_cnt = 0;
  int busy_err = 0;

  always @(posedge Fast_Clock) cyc <= cyc + 1;

  // Write/Done logger, sampled mid-cycle.
  always @(negedge Fast_Clock) begin
    if (Enable_Draw) begin
      wr_x.push_back(int'(Draw_X));
      wr_y.push_back(int'(Draw_Y));
      wr_c.push_back(int'(Draw_Color));
      wr_cyc.push_back(cyc);
      if (Draw_X >= 32'd160 || Draw_Y >= 32'd120) oob_cnt++;
      if (!Busy) busy_err++;
    end
    if (Done) done_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_log();
    wr_x.delete(); wr_y.delete(); wr_c.delete(); wr_cyc.delete(); done_cyc.delete();
    oob_cnt = 0;
    busy_err = 0;
  endtask

  task automatic drive_cmd(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w,
                           input logic [31:0] h, input logic [31:0] c);
    Cmd_X = x; Cmd_Y = y; Cmd_W = w; Cmd_H = h; Cmd_Color = c;
    Cmd_Valid = 1'b1;
  endtask

  // Called at a negedge with Cmd_Valid high; returns the cycle number right after the accept edge.
  task automatic wait_accept(output int acc);
    int n;
    n = 0;
    acc = -1;
    while (n < 200) begin
      if (Cmd_Ready) begin
        @(posedge Fast_Clock); #1;
        acc = cyc;
        break;
      end
      @(negedge Fast_Clock);
      n++;
    end
    if (acc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w,
                       input logic [31:0] h, input logic [31:0] c, output int acc);
    @(negedge Fast_Clock);
    drive_cmd(x, y, w, h, c);
    wait_accept(acc);
    @(negedge Fast_Clock);
    Cmd_Valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cyc.size() < n && k < budget) begin
      @(negedge Fast_Clock); #1;
      k++;
    end
    if (done_cyc.size() < n) check("done_timeout", done_cyc.size(), n);
  endtask

  int a, a2, errs, rdy_hi;
  int ex1_x[4] = '{3, 4, 3, 4};
  int ex1_y[4] = '{5, 5, 6, 6};
  int ex2_x[4] = '{158, 159, 158, 159};
  int ex2_y[4] = '{118, 118, 119, 119};

  initial begin
    Reset_N = 1'b0;
    Cmd_Valid = 1'b0;
    Cmd_X = '0; Cmd_Y = '0; Cmd_W = '0; Cmd_H = '0; Cmd_Color = '0;
    repeat (3) @(negedge Fast_Clock);

    // Reset state
    check("rst_ready", Cmd_Ready, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_enable", Enable_Draw, 0);
    check("rst_xyc", {Draw_X, Draw_Y} | 64'(Draw_Color), 0);
    Reset_N = 1'b1;
    repeat (2) @(negedge Fast_Clock);

    // 1. Basic 2x2 fill
    clear_log();
    issue(32'd3, 32'd5, 32'd2, 32'd2, 32'h1FF, a);
    wait_done(1, 50);
    check("t1_count", wr_x.size(), 4);
    for (int i = 0; i < 4 && i < wr_x.size(); i++) begin
      check($sformatf("t1_x%0d", i), wr_x[i], ex1_x[i]);
      check($sformatf("t1_y%0d", i), wr_y[i], ex1_y[i]);
      check($sformatf("t1_c%0d", i), wr_c[i], 32'h1FF);
      check($sformatf("t1_cyc%0d", i), wr_cyc[i], a + 2 + i);
    end
    if (done_cyc.size() > 0) check("t1_done_cyc", done_cyc[0], a + 6);
    repeat (2) @(negedge Fast_Clock);

    // 2. Clipping at the bottom-right corner
    clear_log();
    issue(32'd158, 32'd118, 32'd5, 32'd5, 32'h038, a);
    wait_done(1, 50);
    check("t2_count", wr_x.size(), 4);
    for (int i = 0; i < 4 && i < wr_x.size(); i++) begin
      check($sformatf("t2_x%0d", i), wr_x[i], ex2_x[i]);
      check($sformatf("t2_y%0d", i), wr_y[i], ex2_y[i]);
      check($sformatf("t2_c%0d", i), wr_c[i], 32'h038);
    end
    check("t2_oob", oob_cnt, 0);
    repeat (2) @(negedge Fast_Clock);

    // 3. Degenerate commands: zero width, off-screen, huge X
    clear_log();
    issue(32'd10, 32'd10, 32'd0, 32'd4, 32'h1, a);
    wait_done(1, 20);
    check("t3a_count", wr_x.size(), 0);
    if (done_cyc.size() > 0) check("t3a_done_cyc", done_cyc[0], a + 2);
    repeat (2) @(negedge Fast_Clock);

    clear_log();
    issue(32'd200, 32'd10, 32'd4, 32'd4, 32'h2, a);
    wait_done(1, 20);
    check("t3b_count", wr_x.size(), 0);
    if (done_cyc.size() > 0) check("t3b_done_cyc", done_cyc[0], a + 2);
    repeat (2) @(negedge Fast_Clock);

    clear_log();
    issue(32'hFFFF_FFF0, 32'd0, 32'h20, 32'd2, 32'h3, a);
    wait_done(1, 20);
    check("t3c_count", wr_x.size(), 0);
    if (done_cyc.size() > 0) check("t3c_done_cyc", done_cyc[0], a + 2);
    repeat (2) @(negedge Fast_Clock);

    // Width so large that a 32-bit sum would wrap; must clip to the right edge
    clear_log();
    issue(32'd10, 32'd119, 32'hFFFF_FFFF, 32'd1, 32'h007, a);
    wait_done(1, 400);
    check("t3d_count", wr_x.size(), 150);
    if (wr_x.size() == 150) begin
      check("t3d_first_x", wr_x[0], 10);
      check("t3d_last_x", wr_x[149], 159);
      check("t3d_last_y", wr_y[149], 119);
    end
    if (done_cyc.size() > 0) check("t3d_done_cyc", done_cyc[0], a + 152);
    repeat (2) @(negedge Fast_Clock);

    // 4. Full clear with a stray command pulsed mid-fill
    clear_log();
    issue(32'd0, 32'd0, 32'd160, 32'd120, 32'd0, a);
    repeat (100) @(negedge Fast_Clock);
    drive_cmd(32'd1, 32'd1, 32'd1, 32'd1, 32'h1FF);
    repeat (3) @(negedge Fast_Clock);
    Cmd_Valid = 1'b0;
    wait_done(1, 20000);
    repeat (10) @(negedge Fast_Clock);
    check("t4_count", wr_x.size(), 19200);
    errs = 0;
    for (int i = 0; i < wr_x.size(); i++) begin
      if (wr_x[i] != i % 160 || wr_y[i] != i / 160 || wr_c[i] != 0 || wr_cyc[i] != a + 2 + i)
        errs++;
    end
    check("t4_raster", errs, 0);
    if (wr_x.size() > 0) begin
      check("t4_last_x", wr_x[wr_x.size()-1], 159);
      check("t4_last_y", wr_y[wr_y.size()-1], 119);
    end
    check("t4_busy", busy_err, 0);
    check("t4_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("t4_done_cyc", done_cyc[0], a + 19202);
    check("t4_ready", Cmd_Ready, 1);

    // 5. Reset in the middle of a draw
    clear_log();
    issue(32'd0, 32'd0, 32'd160, 32'd120, 32'h0AA, a);
    for (int k = 0; k < 100 && wr_x.size() < 10; k++) begin
      @(negedge Fast_Clock); #1;
    end
    Reset_N = 1'b0;
    #1;
    check("t5_rst_enable", Enable_Draw, 0);
    check("t5_rst_x", Draw_X, 0);
    check("t5_rst_y", Draw_Y, 0);
    check("t5_rst_color", Draw_Color, 0);
    check("t5_rst_ready", Cmd_Ready, 1);
    check("t5_rst_busy", Busy, 0);
    repeat (2) @(negedge Fast_Clock);
    Reset_N = 1'b1;
    repeat (5) @(negedge Fast_Clock);
    check("t5_writes", wr_x.size(), 10);
    check("t5_no_done", done_cyc.size(), 0);
    check("t5_ready_after", Cmd_Ready, 1);
    clear_log();
    issue(32'd10, 32'd20, 32'd3, 32'd1, 32'h155, a);
    wait_done(1, 50);
    check("t5_new_count", wr_x.size(), 3);
    for (int i = 0; i < 3 && i < wr_x.size(); i++) begin
      check($sformatf("t5_new_x%0d", i), wr_x[i], 10 + i);
      check($sformatf("t5_new_y%0d", i), wr_y[i], 20);
      check($sformatf("t5_new_c%0d", i), wr_c[i], 32'h155);
    end
    repeat (2) @(negedge Fast_Clock);

    // 6. Back-to-back 1x1 commands with Cmd_Valid held
    clear_log();
    @(negedge Fast_Clock);
    drive_cmd(32'd5, 32'd5, 32'd1, 32'd1, 32'h001);
    wait_accept(a);
    @(negedge Fast_Clock);
    drive_cmd(32'd7, 32'd9, 32'd1, 32'd1, 32'h002);
    rdy_hi = 0;
    for (int k = 0; k < 3; k++) begin
      rdy_hi += int'(Cmd_Ready);
      @(negedge Fast_Clock);
    end
    check("t6_ready_low", rdy_hi, 0);
    wait_accept(a2);
    check("t6_accept_gap", a2 - a, 4);
    @(negedge Fast_Clock);
    Cmd_Valid = 1'b0;
    wait_done(2, 50);
    check("t6_count", wr_x.size(), 2);
    if (wr_x.size() == 2) begin
      check("t6_x0", wr_x[0], 5);
      check("t6_y0", wr_y[0], 5);
      check("t6_c0", wr_c[0], 1);
      check("t6_x1", wr_x[1], 7);
      check("t6_y1", wr_y[1], 9);
      check("t6_c1", wr_c[1], 2);
    end
    if (done_cyc.size() == 2) begin
      check("t6_done_gap", done_cyc[1] - done_cyc[0], 4);
      check("t6_done0_cyc", done_cyc[0], a + 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
